// File: rtl/axis_splitter_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_splitter_if
// Brief    : Wide AXI-Stream input plus per-lane narrow outputs of the splitter
// Revision : 1.0 - initial release
// ============================================================================
interface axis_splitter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 4
);
    logic [DATA_WIDTH*CHANNELS-1:0] s_axis_0_tdata;
    logic [CHANNELS-1:0]            s_axis_0_tkeep;
    logic                           s_axis_0_tlast;
    logic                           s_axis_0_tvalid;
    logic                           s_axis_0_tready;

    logic [DATA_WIDTH*CHANNELS-1:0] m_axis_0_tdata;
    logic [CHANNELS-1:0]            m_axis_0_tlast;
    logic [CHANNELS-1:0]            m_axis_0_tvalid;
    logic [CHANNELS-1:0]            m_axis_0_tready;

    // Environment side: produces the wide word, consumes the lanes
    modport master (
        output s_axis_0_tdata, s_axis_0_tkeep, s_axis_0_tlast, s_axis_0_tvalid,
        output m_axis_0_tready,
        input  s_axis_0_tready,
        input  m_axis_0_tdata, m_axis_0_tlast, m_axis_0_tvalid
    );

    modport slave (
        input  s_axis_0_tdata, s_axis_0_tkeep, s_axis_0_tlast, s_axis_0_tvalid,
        input  m_axis_0_tready,
        output s_axis_0_tready,
        output m_axis_0_tdata, m_axis_0_tlast, m_axis_0_tvalid
    );
endinterface
`default_nettype wire

// File: rtl/axis_splitter.sv
`default_nettype none
// ============================================================================
// Module   : axis_splitter
// Brief    : Fans one wide tkeep-qualified AXI-Stream word out to per-lane FIFOs
// Revision : 1.0 - initial release
// ============================================================================
module axis_splitter #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  wire             clk,
    input  wire             rst,
    axis_splitter_if.slave  bus
);
    localparam int                 C_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                 C_CNT_W = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_FULL  = C_CNT_W'(FIFO_DEPTH);

    logic                           r_rst_q;
    logic                           w_s_tready;
    logic [CHANNELS-1:0]            w_full;
    logic [CHANNELS-1:0]            w_m_tvalid;
    logic [CHANNELS-1:0]            w_m_tlast;
    logic [DATA_WIDTH*CHANNELS-1:0] w_m_tdata;

    // Registered copy of rst keeps tready low for the whole reset window
    // without creating a combinational path from the rst pin.
    always_ff @(posedge clk) begin
        r_rst_q <= rst;
    end

    assign w_s_tready = !r_rst_q && !(|w_full);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            logic [DATA_WIDTH:0]    r_mem [FIFO_DEPTH];
            logic [C_PTR_W-1:0]     r_wr_ptr;
            logic [C_PTR_W-1:0]     r_rd_ptr;
            logic [C_CNT_W-1:0]     r_count;
            logic                   w_wr;
            logic                   w_rd;

            assign w_wr = bus.s_axis_0_tvalid && w_s_tready && bus.s_axis_0_tkeep[gi];
            assign w_rd = w_m_tvalid[gi] && bus.m_axis_0_tready[gi];

            always_ff @(posedge clk) begin
                if (w_wr) begin
                    r_mem[r_wr_ptr] <= {bus.s_axis_0_tlast,
                                        bus.s_axis_0_tdata[DATA_WIDTH*gi +: DATA_WIDTH]};
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_wr) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_rd) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    case ({w_wr, w_rd})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end

            assign w_full[gi]                               = (r_count == C_FULL);
            assign w_m_tvalid[gi]                           = (r_count != '0);
            assign w_m_tdata[DATA_WIDTH*gi +: DATA_WIDTH]   = r_mem[r_rd_ptr][DATA_WIDTH-1:0];
            assign w_m_tlast[gi]                            = r_mem[r_rd_ptr][DATA_WIDTH];
        end
    endgenerate

    assign bus.s_axis_0_tready = w_s_tready;
    assign bus.m_axis_0_tvalid = w_m_tvalid;
    assign bus.m_axis_0_tdata  = w_m_tdata;
    assign bus.m_axis_0_tlast  = w_m_tlast;

endmodule
`default_nettype wire

// File: tb/tb_axis_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_splitter
// Brief    : Self-checking bench for axis_splitter against per-lane queue model
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_splitter;
    localparam int DW = 16;
    localparam int CH = 4;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    axis_splitter_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

    axis_splitter #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one queue of {last, data} per lane
    logic [DW:0] q [CH][$];
    bit          exp_rst_q = 1'b1;

    function automatic bit exp_ready();
        for (int i = 0; i < CH; i++) if (q[i].size() >= FD) return 1'b0;
        return !exp_rst_q;
    endfunction

    function automatic logic [CH-1:0] exp_valid();
        logic [CH-1:0] v = '0;
        for (int i = 0; i < CH; i++) v[i] = (q[i].size() != 0);
        return v;
    endfunction

    function automatic logic [DW*CH-1:0] exp_data();
        logic [DW*CH-1:0] d = '0;
        for (int i = 0; i < CH; i++) if (q[i].size() != 0) d[i*DW +: DW] = q[i][0][DW-1:0];
        return d;
    endfunction

    function automatic logic [CH-1:0] exp_last();
        logic [CH-1:0] l = '0;
        for (int i = 0; i < CH; i++) if (q[i].size() != 0) l[i] = q[i][0][DW];
        return l;
    endfunction

    function automatic logic [DW*CH-1:0] data_mask();
        logic [DW*CH-1:0] m = '0;
        for (int i = 0; i < CH; i++) if (q[i].size() != 0) m[i*DW +: DW] = '1;
        return m;
    endfunction

    function automatic logic [DW*CH-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic drive(input bit v, input logic [CH-1:0] k, input bit l,
                         input logic [DW*CH-1:0] d);
        bus.s_axis_0_tvalid = v;
        bus.s_axis_0_tkeep  = k;
        bus.s_axis_0_tlast  = l;
        bus.s_axis_0_tdata  = d;
    endtask

    // One clock: the model decides handshakes from what the bench drives
    // and its own occupancy, then applies them at the edge.
    task automatic tick();
        bit            acc;
        bit [CH-1:0]   rd;
        acc = bus.s_axis_0_tvalid && exp_ready();
        for (int i = 0; i < CH; i++) rd[i] = bus.m_axis_0_tready[i] && (q[i].size() != 0);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < CH; i++) q[i].delete();
            exp_rst_q = 1'b1;
        end else begin
            exp_rst_q = 1'b0;
            for (int i = 0; i < CH; i++) begin
                if (rd[i]) void'(q[i].pop_front());
                if (acc && bus.s_axis_0_tkeep[i])
                    q[i].push_back({bus.s_axis_0_tlast, bus.s_axis_0_tdata[i*DW +: DW]});
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.m_axis_0_tready = '1;
        drive(1'b1, '1, 1'b0, rand_word());
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (bus.s_axis_0_tready !== 1'b0 || bus.m_axis_0_tvalid !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: tready=%b tvalid=%b, required tready=0 tvalid=0",
                         bus.s_axis_0_tready, bus.m_axis_0_tvalid);
            end
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (bus.s_axis_0_tready !== 1'b1 || bus.m_axis_0_tvalid !== '0) begin
            n_fail++;
            $display("FAIL reset_release: tready=%b tvalid=%b, required tready=1 tvalid=0",
                     bus.s_axis_0_tready, bus.m_axis_0_tvalid);
        end
        drive(1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_streaming();
        logic [DW*CH-1:0] d;
        bus.m_axis_0_tready = '1;
        for (int n = 0; n < 23; n++) begin
            if (n < 20) begin
                for (int i = 0; i < CH; i++) d[i*DW +: DW] = 16'(16'hBEBE + i + 4*n);
                drive(1'b1, '1, (n == 19), d);
            end else begin
                drive(1'b0, '0, 1'b0, '0);
            end
            tick();
            n_tests++;
            if (bus.s_axis_0_tready !== exp_ready() || bus.m_axis_0_tvalid !== exp_valid()) begin
                n_fail++;
                $display("FAIL stream_ctrl n=%0d: tready=%b tvalid=%b, required %b %b",
                         n, bus.s_axis_0_tready, bus.m_axis_0_tvalid, exp_ready(), exp_valid());
            end
            n_tests++;
            if ((bus.m_axis_0_tdata & data_mask()) !== exp_data() ||
                (bus.m_axis_0_tlast & exp_valid()) !== exp_last()) begin
                n_fail++;
                $display("FAIL stream_data n=%0d: data=%h last=%b, required %h %b",
                         n, bus.m_axis_0_tdata, bus.m_axis_0_tlast, exp_data(), exp_last());
            end
        end
    endtask

    task automatic test_sparse();
        bus.m_axis_0_tready = '1;
        for (int n = 0; n < 10; n++) begin
            if (n < 8) drive(1'b1, (n % 2 == 0) ? 4'b0101 : 4'b1010, (n == 7), rand_word());
            else       drive(1'b0, '0, 1'b0, '0);
            tick();
            n_tests++;
            if (bus.m_axis_0_tvalid !== exp_valid() ||
                (bus.m_axis_0_tdata & data_mask()) !== exp_data() ||
                (bus.m_axis_0_tlast & exp_valid()) !== exp_last()) begin
                n_fail++;
                $display("FAIL sparse n=%0d: tvalid=%b data=%h last=%b, required %b %h %b",
                         n, bus.m_axis_0_tvalid, bus.m_axis_0_tdata, bus.m_axis_0_tlast,
                         exp_valid(), exp_data(), exp_last());
            end
        end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        bus.m_axis_0_tready = 4'b1011;
        for (int n = 0; n < 8; n++) begin
            drive(1'b1, '1, 1'b0, rand_word());
            if (bus.s_axis_0_tready === 1'b1) accepted++;
            tick();
            n_tests++;
            if (bus.s_axis_0_tready !== exp_ready() || bus.m_axis_0_tvalid !== exp_valid() ||
                (bus.m_axis_0_tdata & data_mask()) !== exp_data()) begin
                n_fail++;
                $display("FAIL bp_stall n=%0d: tready=%b tvalid=%b data=%h, required %b %b %h",
                         n, bus.s_axis_0_tready, bus.m_axis_0_tvalid, bus.m_axis_0_tdata,
                         exp_ready(), exp_valid(), exp_data());
            end
        end
        n_tests++;
        if (accepted != FD) begin
            n_fail++;
            $display("FAIL bp_accept_count: accepted %0d words, required %0d", accepted, FD);
        end
        bus.m_axis_0_tready = 4'b1111;
        tick();
        bus.m_axis_0_tready = 4'b1011;
        n_tests++;
        if (bus.s_axis_0_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: tready=%b, required 1", bus.s_axis_0_tready);
        end
        for (int n = 0; n < 9; n++) begin
            if (n == 1) begin
                drive(1'b0, '0, 1'b0, '0);
                bus.m_axis_0_tready = '1;
            end
            tick();
            n_tests++;
            if (bus.s_axis_0_tready !== exp_ready() || bus.m_axis_0_tvalid !== exp_valid() ||
                (bus.m_axis_0_tdata & data_mask()) !== exp_data()) begin
                n_fail++;
                $display("FAIL bp_drain n=%0d: tready=%b tvalid=%b data=%h, required %b %b %h",
                         n, bus.s_axis_0_tready, bus.m_axis_0_tvalid, bus.m_axis_0_tdata,
                         exp_ready(), exp_valid(), exp_data());
            end
        end
    endtask

    task automatic test_keep_zero();
        bus.m_axis_0_tready = '1;
        for (int n = 0; n < 5; n++) begin
            case (n)
                0:       drive(1'b1, '1, 1'b0, rand_word());
                1:       drive(1'b1, '0, 1'b1, rand_word());
                2:       drive(1'b1, '1, 1'b0, rand_word());
                default: drive(1'b0, '0, 1'b0, '0);
            endcase
            if (n == 1) begin
                n_tests++;
                if (bus.s_axis_0_tready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL keep0_ready: tready=%b, required 1", bus.s_axis_0_tready);
                end
            end
            tick();
            n_tests++;
            if (bus.m_axis_0_tvalid !== exp_valid() ||
                (bus.m_axis_0_tdata & data_mask()) !== exp_data() ||
                (bus.m_axis_0_tlast & exp_valid()) !== exp_last()) begin
                n_fail++;
                $display("FAIL keep0 n=%0d: tvalid=%b data=%h last=%b, required %b %h %b",
                         n, bus.m_axis_0_tvalid, bus.m_axis_0_tdata, bus.m_axis_0_tlast,
                         exp_valid(), exp_data(), exp_last());
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.m_axis_0_tready = '0;
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, '1, 1'b0, rand_word());
            tick();
        end
        drive(1'b0, '0, 1'b0, '0);
        rst = 1'b1;
        tick();
        n_tests++;
        if (bus.m_axis_0_tvalid !== '0 || bus.s_axis_0_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: tvalid=%b tready=%b, required 0 0",
                     bus.m_axis_0_tvalid, bus.s_axis_0_tready);
        end
        rst = 1'b0;
        tick();
        bus.m_axis_0_tready = '1;
        for (int n = 0; n < 4; n++) begin
            case (n)
                0:       drive(1'b1, '1, 1'b0, {CH{16'hDEAD}});
                1:       drive(1'b1, '1, 1'b1, {CH{16'hCAFE}});
                default: drive(1'b0, '0, 1'b0, '0);
            endcase
            tick();
            n_tests++;
            if (bus.m_axis_0_tvalid !== exp_valid() ||
                (bus.m_axis_0_tdata & data_mask()) !== exp_data() ||
                (bus.m_axis_0_tlast & exp_valid()) !== exp_last()) begin
                n_fail++;
                $display("FAIL post_reset n=%0d: tvalid=%b data=%h last=%b, required %b %h %b",
                         n, bus.m_axis_0_tvalid, bus.m_axis_0_tdata, bus.m_axis_0_tlast,
                         exp_valid(), exp_data(), exp_last());
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), CH'($urandom), 1'($urandom), rand_word());
            bus.m_axis_0_tready = CH'($urandom);
            tick();
            n_tests++;
            if (bus.s_axis_0_tready !== exp_ready() || bus.m_axis_0_tvalid !== exp_valid() ||
                (bus.m_axis_0_tdata & data_mask()) !== exp_data() ||
                (bus.m_axis_0_tlast & exp_valid()) !== exp_last()) begin
                n_fail++;
                $display("FAIL random n=%0d: tready=%b tvalid=%b data=%h last=%b, required %b %b %h %b",
                         n, bus.s_axis_0_tready, bus.m_axis_0_tvalid, bus.m_axis_0_tdata,
                         bus.m_axis_0_tlast, exp_ready(), exp_valid(), exp_data(), exp_last());
            end
        end
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, '0);
        bus.m_axis_0_tready = '0;
        #2;
        test_reset();
        test_streaming();
        test_sparse();
        test_backpressure();
        test_keep_zero();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_splitter.md
# axis_splitter

Downstream counterpart of the channel combiner: takes one wide AXI-Stream word carrying CHANNELS lanes of DATA_WIDTH bits, each qualified by a tkeep bit, and fans it out into CHANNELS independent narrow AXI-Stream outputs. Each lane has its own FIFO_DEPTH-entry buffer, so a slow consumer on one channel does not stall the others until that channel's buffer fills. It sits between the combined output stream and the per-channel compute consumers.

## Interface
- DATA_WIDTH, 16, bits per lane
- CHANNELS, 4, number of lanes / output streams
- FIFO_DEPTH, 4, entries per lane buffer; power of two, >= 2

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axis_0_tdata  in  DATA_WIDTH*CHANNELS  lane i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
- s_axis_0_tkeep  in  CHANNELS  bit i = lane i carries a beat
- s_axis_0_tlast  in  1  end of frame for all kept lanes
- s_axis_0_tvalid  in  1  input word valid
- s_axis_0_tready  out  1  input word accepted this cycle when high with tvalid
- m_axis_0_tdata  out  DATA_WIDTH*CHANNELS  head data of lane i buffer, same packing
- m_axis_0_tlast  out  CHANNELS  per-lane frame end
- m_axis_0_tvalid  out  CHANNELS  per-lane buffer non-empty
- m_axis_0_tready  in  CHANNELS  per-lane consumer ready

## Operation
- Per lane i: circular buffer of FIFO_DEPTH entries of {data, last}, write pointer, read pointer, occupancy count 0..FIFO_DEPTH (log2(FIFO_DEPTH)+1 bits). Pointers wrap modulo FIFO_DEPTH.
- full_i = (count_i == FIFO_DEPTH). s_axis_0_tready = !rst_state && no lane full. tready does not depend on tkeep, tdata or tvalid.
- Input handshake (tvalid && tready): for every i with tkeep[i]=1, write {lane i data, s_axis_0_tlast} at wr_ptr_i, advance wr_ptr_i. Lanes with tkeep[i]=0 are untouched.
- tkeep = 0 word: accepted and discarded, including its tlast; no lane changes.
- tlast is delivered only to kept lanes; an unkept lane sees no frame boundary from that word.
- Output per lane: m_axis_0_tvalid[i] = (count_i != 0); tdata/tlast = entry at rd_ptr_i. Handshake advances rd_ptr_i, decrements count_i.
- Simultaneous write and read on the same lane: count unchanged, both pointers advance.
- Lane full: write blocked for all lanes (tready low) even if that lane reads the same cycle; no bypass. tready rises the cycle after the read frees a slot.
- Lanes are fully independent on the output side; ordering within a lane is preserved, no ordering between lanes.
- m_axis_0_tdata/tlast on a lane with tvalid low are don't-care; the bench does not check them.

## Timing
- Reset (rst high at a clk edge): all counts and pointers 0; next cycle m_axis_0_tvalid = 0, s_axis_0_tready = 0 while rst is high; tready = 1 on the first cycle after rst is deasserted. Buffer contents are not reset.
- rst mid-operation discards all buffered beats on the same edge; partial frames are lost.
- Latency: a word accepted at edge N is presented on kept lanes after edge N (1 cycle), assuming the lane was empty.
- Throughput: one input word per cycle while no lane is full; one beat per lane per cycle out.
- tready is a registered-state function (counts only); no combinational path from any input to tready or tvalid.
- AXIS rules: outputs hold tdata/tlast/tvalid stable while tvalid && !tready.

## Test plan
- Reset: hold rst 3 cycles with tvalid=1 -> tready=0 and all m tvalid=0 throughout; tready=1 the first cycle after release; no beat written.
- Full-width streaming: words tkeep=4'hF, lane i data = 16'hBEBE+i+4*n for n=0..19, tlast on n=19, all m tready=1 -> each lane emits 20 beats in order, 1-cycle latency, tlast only on beat 20, tready never drops.
- Sparse keep: alternate tkeep 4'b0101 / 4'b1010 for 8 words, tlast on word 8 (keep 4'b1010) -> each lane gets 4 beats; only lanes 1 and 3 see tlast; lanes 0 and 2 see no tlast.
- Backpressure: lane 2 tready=0, others 1, stream tkeep=4'hF -> tready falls after exactly FIFO_DEPTH=4 accepted words; other lanes drain 4 beats; releasing lane 2 for one beat raises tready one cycle later; no loss or duplication.
- tkeep=0 word with tlast=1 between data words -> accepted in one cycle, no lane gets a beat or tlast.
- Reset mid-frame with 3 beats buffered per lane -> all m tvalid=0 next cycle; subsequent frame 16'hDEAD/16'hCAFE is emitted with no stale data.
